// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks.
// Holds the rounding-mode encodings used by frac_mult_pipe and the butterfly.
// No ports: package only.
package fft_pkg;

  // Rounding modes applied when dropping the coefficient's fractional bits.
  // Code 2'b11 is reserved and behaves exactly like MODE_FLOOR.
  typedef enum logic [1:0] {
    MODE_FLOOR     = 2'b00,
    MODE_RHU       = 2'b01,
    MODE_TZERO     = 2'b10,
    MODE_FLOOR_ALT = 2'b11
  } round_mode_e;

endpackage

// File: rtl/frac_mult_pipe_if.sv
// Handshake bus for frac_mult_pipe.
// Input side : in_valid/in_ready plus in_data, in_coef, in_mode.
// Output side: out_valid/out_ready plus out_data, out_sat.
// modport master is the producer/consumer around the block (e.g. a bench or
// the surrounding datapath); modport slave is the multiplier itself.
interface frac_mult_pipe_if #(
  parameter int DATA_W = 17,
  parameter int COEF_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [COEF_W-1:0] in_coef;
  logic [1:0]               in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, in_coef, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_coef, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/frac_round_sat.sv
// Combinational rounding and saturation of a full-width signed product.
// Ports:
//   i_prod : signed product, DATA_W+COEF_W bits, FRAC_W fractional bits
//   i_mode : rounding mode (fft_pkg::round_mode_e)
//   o_data : rounded result clamped to DATA_W bits
//   o_sat  : 1 when the rounded value did not fit and was clamped
module frac_round_sat
  import fft_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int COEF_W = 8,
  parameter int FRAC_W = 7
) (
  input  logic signed [DATA_W+COEF_W-1:0] i_prod,
  input  round_mode_e                     i_mode,
  output logic signed [DATA_W-1:0]        o_data,
  output logic                            o_sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  // One guard bit above the product keeps the bias add from wrapping.
  localparam int EXT_W  = PROD_W + 1;

  localparam logic [EXT_W-1:0] ONE      = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic [EXT_W-1:0] RHU_BIAS = ONE << (FRAC_W - 1);
  localparam logic [EXT_W-1:0] TZ_BIAS  = (ONE << FRAC_W) - ONE;

  logic signed [EXT_W-1:0]  w_ext;
  logic signed [EXT_W-1:0]  w_bias;
  logic signed [EXT_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_shift;
  logic [EXT_W-DATA_W:0]    w_hi;
  logic                     w_fits;

  // Bias-then-arithmetic-shift implements all three modes. Truncation toward
  // zero only needs the bias for negative products, which turns the floor of
  // the shift into a ceiling. The result fits when every bit from the DATA_W
  // sign position upward is a copy of the sign.
  always_comb begin
    w_ext  = {i_prod[PROD_W-1], i_prod};
    w_bias = '0;
    case (i_mode)
      MODE_RHU:   w_bias = RHU_BIAS;
      MODE_TZERO: w_bias = i_prod[PROD_W-1] ? TZ_BIAS : '0;
      default:    w_bias = '0;
    endcase
    w_sum   = w_ext + w_bias;
    w_shift = w_sum >>> FRAC_W;
    w_hi    = w_shift[EXT_W-1:DATA_W-1];
    w_fits  = (&w_hi) || !(|w_hi);
    o_sat   = !w_fits;
    if (w_fits) begin
      o_data = w_shift[DATA_W-1:0];
    end else if (w_shift[EXT_W-1]) begin
      o_data = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      o_data = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/frac_mult_pipe.sv
// Three-stage fractional multiplier: data * coef scaled by 2^-FRAC_W with
// selectable rounding and saturation, valid/ready flow control per stage.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all stage valids
//   bus : frac_mult_pipe_if.slave (in_valid/in_ready/in_data/in_coef/in_mode,
//         out_valid/out_ready/out_data/out_sat)
// Stages: S1 operands+mode, S2 full signed product, S3 rounded result+flag.
module frac_mult_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int COEF_W = 8,
  parameter int FRAC_W = 7
) (
  input logic           clk,
  input logic           rst,
  frac_mult_pipe_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic                     r_s1Valid;
  logic signed [DATA_W-1:0] r_s1Data;
  logic signed [COEF_W-1:0] r_s1Coef;
  round_mode_e              r_s1Mode;

  logic                     r_s2Valid;
  logic signed [PROD_W-1:0] r_s2Prod;
  round_mode_e              r_s2Mode;

  logic                     r_s3Valid;
  logic signed [DATA_W-1:0] r_s3Data;
  logic                     r_s3Sat;

  logic                     w_s1Adv;
  logic                     w_s2Adv;
  logic                     w_s3Adv;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_rsData;
  logic                     w_rsSat;

  // A stage may load when it is empty or its contents move on this edge, so
  // bubbles collapse. in_ready depends only on out_ready and the valids.
  always_comb begin
    w_s3Adv = !r_s3Valid || bus.out_ready;
    w_s2Adv = !r_s2Valid || w_s3Adv;
    w_s1Adv = !r_s1Valid || w_s2Adv;
  end

  assign bus.in_ready  = w_s1Adv;
  assign bus.out_valid = r_s3Valid;
  assign bus.out_data  = r_s3Data;
  assign bus.out_sat   = r_s3Sat;

  // Both operands are sign-extended to the full product width first, so the
  // two's-complement multiply is exact without any magnitude conversion.
  assign w_prod = PROD_W'(r_s1Data) * PROD_W'(r_s1Coef);

  // S1 valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= bus.in_valid;
    end
  end

  // S1 operands are only captured on an accepted sample.
  always_ff @(posedge clk) begin
    if (w_s1Adv && bus.in_valid) begin
      r_s1Data <= bus.in_data;
      r_s1Coef <= bus.in_coef;
      r_s1Mode <= round_mode_e'(bus.in_mode);
    end
  end

  // S2 valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
    end
  end

  // S2 product and mode.
  always_ff @(posedge clk) begin
    if (w_s2Adv && r_s1Valid) begin
      r_s2Prod <= w_prod;
      r_s2Mode <= r_s1Mode;
    end
  end

  frac_round_sat #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W)
  ) u_roundSat (
    .i_prod (r_s2Prod),
    .i_mode (r_s2Mode),
    .o_data (w_rsData),
    .o_sat  (w_rsSat)
  );

  // S3 output register; data and flag keep their last value when a bubble
  // passes through so the bus only changes when a real sample lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3Valid <= 1'b0;
      r_s3Data  <= '0;
      r_s3Sat   <= 1'b0;
    end else if (w_s3Adv) begin
      r_s3Valid <= r_s2Valid;
      if (r_s2Valid) begin
        r_s3Data <= w_rsData;
        r_s3Sat  <= w_rsSat;
      end
    end
  end

endmodule

// File: tb/tb_frac_mult_pipe.sv
// Self-checking bench for frac_mult_pipe: directed corner vectors, throughput,
// backpressure, mid-stream reset and randomized operands against an
// arithmetic reference model.
module tb_frac_mult_pipe;

  localparam int DATA_W = 17;
  localparam int COEF_W = 8;
  localparam int FRAC_W = 7;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sat;
    int                acceptCyc;
    logic              chkLat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vecCount  = 0;
  int   missCount = 0;
  int   cyc       = 0;
  int   occ       = 0;
  int   readyMode = 0;
  logic latChk    = 1'b0;
  exp_t expQ[$];

  logic              prevRst   = 1'b0;
  logic              prevStall = 1'b0;
  logic [DATA_W-1:0] prevData;
  logic              prevSat;

  frac_mult_pipe_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  frac_mult_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d",
               tag, observed, expected, cyc);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: exact integer product, scaled with ordinary division rules,
  // then clamped to the signed DATA_W range.
  function automatic void refModel(input logic signed [DATA_W-1:0] d,
                                   input logic signed [COEF_W-1:0] c,
                                   input logic [1:0] m,
                                   output logic [DATA_W-1:0] q,
                                   output logic s);
    longint p, scale, r, hi, lo;
    p     = longint'(d) * longint'(c);
    scale = longint'(1) << FRAC_W;
    case (m)
      2'b01:   r = floorDiv(p + scale / 2, scale);
      2'b10:   r = p / scale;
      default: r = floorDiv(p, scale);
    endcase
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -hi - 1;
    s  = 1'b0;
    if (r > hi) begin
      r = hi;
      s = 1'b1;
    end else if (r < lo) begin
      r = lo;
      s = 1'b1;
    end
    q = DATA_W'(r);
  endfunction

  // Output-side ready pattern: 0 always ready, 1 random, 2 stalled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor on the falling edge: predicts the handshakes of the coming
  // rising edge, keeps the scoreboard and checks every visible rule.
  always @(negedge clk) begin
    exp_t e;
    logic [DATA_W-1:0] q;
    logic s;
    cyc++;
    if (prevRst) begin
      checkOutput("rstOutValid", DATA_W'(bus.out_valid), '0);
      checkOutput("rstOutData", bus.out_data, '0);
      checkOutput("rstOutSat", DATA_W'(bus.out_sat), '0);
      checkOutput("rstInReady", DATA_W'(bus.in_ready), DATA_W'(1));
    end
    if (prevStall) begin
      checkOutput("stallValid", DATA_W'(bus.out_valid), DATA_W'(1));
      checkOutput("stallData", bus.out_data, prevData);
      checkOutput("stallSat", DATA_W'(bus.out_sat), DATA_W'(prevSat));
    end
    if (rst) begin
      expQ.delete();
      occ       = 0;
      prevRst   = 1'b1;
      prevStall = 1'b0;
    end else begin
      prevRst = 1'b0;
      checkOutput("inReady", DATA_W'(bus.in_ready),
                  DATA_W'(!(occ == 3 && !bus.out_ready)));
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", DATA_W'(bus.out_valid), '0);
      end else if (bus.out_valid && bus.out_ready) begin
        e = expQ.pop_front();
        checkOutput("outData", bus.out_data, e.data);
        checkOutput("outSat", DATA_W'(bus.out_sat), DATA_W'(e.sat));
        if (e.chkLat) checkOutput("latency", DATA_W'(cyc - e.acceptCyc), DATA_W'(3));
        occ--;
      end
      if (bus.in_valid && bus.in_ready) begin
        refModel(bus.in_data, bus.in_coef, bus.in_mode, q, s);
        e.data      = q;
        e.sat       = s;
        e.acceptCyc = cyc;
        e.chkLat    = latChk;
        expQ.push_back(e);
        occ++;
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      prevSat   = bus.out_sat;
    end
  end

  // Present one sample and hold it until accepted; returns just after the
  // accepting edge so the next call can follow back-to-back.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [COEF_W-1:0] c,
                               input logic [1:0] m);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_coef  = c;
    bus.in_mode  = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) checkOutput("acceptTimeout", DATA_W'(acc), DATA_W'(1));
  endtask

  // Idle with junk on the data lines, which must be ignored.
  task automatic idleCycles(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'($urandom);
    bus.in_coef  = COEF_W'($urandom);
    bus.in_mode  = 2'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainTimeout", DATA_W'(expQ.size()), '0);
  endtask

  task automatic randomSample();
    logic [DATA_W-1:0] d;
    logic [COEF_W-1:0] c;
    case ($urandom_range(0, 5))
      0:       d = {1'b1, {(DATA_W-1){1'b0}}};
      1:       d = {1'b0, {(DATA_W-1){1'b1}}};
      default: d = DATA_W'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0:       c = {1'b1, {(COEF_W-1){1'b0}}};
      1:       c = {1'b0, {(COEF_W-1){1'b1}}};
      default: c = COEF_W'($urandom);
    endcase
    applyStimulus(d, c, 2'($urandom));
  endtask

  initial begin
    int t0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_coef  = '0;
    bus.in_mode  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed corners with latency checking.
    latChk = 1'b1;
    applyStimulus(17'h04000, 8'h40, 2'b00); idleCycles(4);
    applyStimulus(17'h1C000, 8'h40, 2'b00); idleCycles(4);
    applyStimulus(17'h1FFFF, 8'h40, 2'b00); idleCycles(1);
    applyStimulus(17'h1FFFF, 8'h40, 2'b01); idleCycles(1);
    applyStimulus(17'h1FFFF, 8'h40, 2'b10);
    applyStimulus(17'h1FFFF, 8'h40, 2'b11);
    applyStimulus(17'h00001, 8'h40, 2'b01);
    applyStimulus(17'h10000, 8'h80, 2'b00);
    applyStimulus(17'h0FFFF, 8'h80, 2'b00);
    applyStimulus(17'h0FFFF, 8'h7F, 2'b10);
    applyStimulus(17'h10000, 8'h7F, 2'b01);
    idleCycles(5);

    // Full-rate streaming: one acceptance per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) randomSample();
    checkOutput("throughput", DATA_W'(cyc - t0), DATA_W'(8));
    latChk = 1'b0;
    idleCycles(1);
    drain();

    // Backpressure with random out_ready.
    readyMode = 1;
    idleCycles(1);
    for (int i = 0; i < 8; i++) randomSample();
    idleCycles(1);
    drain();

    // Reset with three samples parked in the pipe.
    readyMode = 2;
    idleCycles(2);
    for (int i = 0; i < 3; i++) randomSample();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    readyMode = 0;
    idleCycles(6);
    latChk = 1'b1;
    applyStimulus(17'h04000, 8'h40, 2'b01);
    latChk = 1'b0;
    idleCycles(5);

    // Randomized operands and modes with random stalls and gaps.
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      randomSample();
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(1);
    drain();
    readyMode = 0;
    idleCycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/frac_mult_pipe.md
FRAC_MULT_PIPE -- requirements
Module: frac_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 17: width of the signed data operand and of the result.
REQ-002 SHALL have parameter COEF_W, default 8: width of the signed coefficient (twiddle) operand.
REQ-003 SHALL have parameter FRAC_W, default 7: number of fractional bits in the coefficient; product is scaled by 2^-FRAC_W.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid  in  1  input sample valid.
REQ-007 SHALL have ports: in_ready  out  1  block accepts input this cycle.
REQ-008 SHALL have ports: in_data  in  DATA_W  two's-complement data.
REQ-009 SHALL have ports: in_coef  in  COEF_W  two's-complement coefficient, Q(COEF_W-1-FRAC_W).FRAC_W.
REQ-010 SHALL have ports: in_mode  in  2  rounding mode, sampled with the data.
REQ-011 SHALL have ports: out_valid  out  1  result valid.
REQ-012 SHALL have ports: out_ready  in  1  downstream accepts result.
REQ-013 SHALL have ports: out_data  out  DATA_W  two's-complement result.
REQ-014 SHALL have ports: out_sat  out  1  result was saturated.

Function
REQ-015 SHALL implement a 3-stage pipeline: S1 registers operands+mode, S2 registers full (DATA_W+COEF_W)-bit signed product, S3 registers rounded/saturated result and flag.
REQ-016 SHALL multiply directly in two's complement; no sign-magnitude conversion.
REQ-017 SHALL apply mode 2'b00: floor (arithmetic shift right by FRAC_W).
REQ-018 SHALL apply mode 2'b01: round half up (add 2^(FRAC_W-1), then arithmetic shift).
REQ-019 SHALL apply mode 2'b10: truncate toward zero (add 2^FRAC_W-1 before shift when product negative).
REQ-020 SHALL treat mode 2'b11 as 2'b00.
REQ-021 SHALL compute rounding at DATA_W+COEF_W+1 bits so the rounding add never wraps.
REQ-022 SHALL saturate a shifted result outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] to the nearest bound and set out_sat=1 for that sample; otherwise out_sat=0.
REQ-023 SHALL give latency 3 cycles from accepted input (in_valid&in_ready) to out_valid when out_ready held high.
REQ-024 SHALL sustain throughput of one sample per cycle with out_ready high.
REQ-025 SHALL use per-stage ready: stage k advances when its valid is 0 or stage k+1 advances; in_ready = !S1.valid | S1 advances (bubbles collapse).
REQ-026 SHALL hold out_data, out_sat, out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never drop or duplicate a sample; order preserved.
REQ-028 SHALL ignore in_data/in_coef/in_mode when in_valid=0 or in_ready=0.
REQ-029 SHALL drive in_ready combinationally from out_ready and stage valids only (no dependence on in_valid).

Reset
REQ-030 SHALL on rst=1 clear all stage valids; out_valid=0, out_data=0, out_sat=0 next edge.
REQ-031 SHALL discard in-flight samples when rst asserted mid-operation; no output for them after reset release.
REQ-032 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-033 SHALL place mode encodings (MODE_FLOOR, MODE_RHU, MODE_TZERO) in shared package fft_pkg for use by the butterfly.
REQ-034 SHALL implement S3 combinational round/saturate as sub-module frac_round_sat (parameters DATA_W, COEF_W, FRAC_W).

Verification (defaults DATA_W=17, COEF_W=8, FRAC_W=7)
REQ-035 SHALL cover: data 0x04000, coef 0x40, mode 00 -> out 0x02000, sat 0, after 3 cycles; data 0x1C000 same coef -> 0x1E000.
REQ-036 SHALL cover rounding: data 0x1FFFF (-1), coef 0x40 -> mode 00: 0x1FFFF; mode 01: 0x00000; mode 10: 0x00000; data 0x00001 mode 01 -> 0x00001.
REQ-037 SHALL cover saturation: data 0x10000, coef 0x80 -> out 0x0FFFF, out_sat=1; data 0x0FFFF, coef 0x80 -> 0x10001, sat 0.
REQ-038 SHALL cover backpressure: stream 8 samples, out_ready random 50% -> all 8 results in order, values stable while stalled, in_ready low only when all 3 stages full and out_ready=0.
REQ-039 SHALL cover reset mid-stream: 3 samples in flight, rst 1 cycle -> out_valid=0 next cycle, none of those 3 emitted, next sample emerges 3 cycles after acceptance.
REQ-040 SHALL cover random signed operands, all modes, against a reference model: bit-exact out_data and out_sat.
